snax_hwpe_regfile: RTL and testbench

Memory-mapped job register file for SNAX HWPE accelerators. It sits directly downstream of the SNAX accelerator-to-HWPE control bridge and consumes its 32-bit `hwpe_ctrl_intf_periph` transactions. It holds the engine configuration words, launches jobs through a start pulse, and tracks busy/done status. An optional performance counter can be compiled in.

---
 rtl/snax_hwpe_regfile_pkg.sv | 29 ++
 rtl/hwpe_ctrl_intf_periph.sv | 25 ++
 rtl/snax_hwpe_regfile_perf_cnt.sv | 24 ++
 rtl/snax_hwpe_regfile.sv | 135 +++++++++++++
 tb/tb_snax_hwpe_regfile.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/snax_hwpe_regfile_pkg.sv
// Shared constants and types for the SNAX HWPE job register file.
package snax_hwpe_regfile_pkg;

    localparam logic [5:0] RegTrigger = 6'd0;
    localparam logic [5:0] RegStatus  = 6'd1;
    localparam logic [5:0] RegPerf    = 6'd2;
    localparam logic [5:0] RegCfgBase = 6'd3;

    localparam int unsigned StatBusy = 0;
    localparam int unsigned StatDone = 1;

    typedef enum logic {
        IDLE,
        RUN
    } regfile_state_t;

    // Byte-enabled merge of a write into an existing 32-bit word.
    function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// 32-bit peripheral control bus between the SNAX bridge and HWPE register files.
interface hwpe_ctrl_intf_periph #(
    parameter int unsigned ID_WIDTH = 8
);
    logic                req;
    logic                gnt;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/snax_hwpe_regfile_perf_cnt.sv
// 32-bit saturating cycle counter with synchronous clear and enable.
module snax_hwpe_regfile_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (en_i) begin
            cnt_o <= sat_inc(cnt_o);
        end
    end

endmodule

// File: rtl/snax_hwpe_regfile.sv
// Job register file for SNAX HWPE engines: config words, start/done handshake, status.
// Optional RUN-cycle counter on word 2 when SNAX_HWPE_REGFILE_PERF_EN is defined.
module snax_hwpe_regfile
    import snax_hwpe_regfile_pkg::*;
#(
    parameter int unsigned NumRegs = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    hwpe_ctrl_intf_periph.slave    periph,
    output logic [NumRegs*32-1:0]  cfg_o,
    output logic                   start_o,
    input  logic                   done_i,
    output logic                   irq_o
);

    localparam logic [6:0] CfgEnd = 7'(RegCfgBase + NumRegs);

    regfile_state_t    state_q;
    logic              done_sticky_q;
    logic [31:0]       cfg_q [NumRegs];

    logic [5:0]        word_idx_p0;
    logic [5:0]        cfg_idx_p0;
    logic              wr_p0;
    logic              rd_p0;
    logic              trig_wr_p0;
    logic              stat_clr_p0;
    logic              cfg_hit_p0;
    logic              cfg_wr_p0;
    logic [31:0]       rdata_p0;
    logic              unused_add;

    // Stage p0: decode of the request presented this cycle
    assign periph.gnt   = periph.req;
    assign word_idx_p0  = periph.add[7:2];
    assign cfg_idx_p0   = word_idx_p0 - RegCfgBase;
    assign unused_add   = ^{periph.add[31:8], periph.add[1:0]};

    assign wr_p0        = periph.req && !periph.wen;
    assign rd_p0        = periph.req &&  periph.wen;
    assign cfg_hit_p0   = (word_idx_p0 >= RegCfgBase) && ({1'b0, word_idx_p0} < CfgEnd);
    assign trig_wr_p0   = wr_p0 && (word_idx_p0 == RegTrigger) && (|periph.be);
    assign stat_clr_p0  = wr_p0 && (word_idx_p0 == RegStatus) && periph.be[0] && periph.data[1];
    // Config is frozen while a job runs so the engine sees stable operands.
    assign cfg_wr_p0    = wr_p0 && cfg_hit_p0 && (state_q == IDLE);

`ifdef SNAX_HWPE_REGFILE_PERF_EN
    logic [31:0] perf_cnt;

    snax_hwpe_regfile_perf_cnt u_perf_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  ((state_q == IDLE) && trig_wr_p0),
        .en_i   (state_q == RUN),
        .cnt_o  (perf_cnt)
    );
`endif

    always_comb begin
        rdata_p0 = '0;
        if (rd_p0) begin
            if (word_idx_p0 == RegStatus) begin
                rdata_p0[StatBusy] = (state_q == RUN);
                rdata_p0[StatDone] = done_sticky_q;
`ifdef SNAX_HWPE_REGFILE_PERF_EN
            end else if (word_idx_p0 == RegPerf) begin
                rdata_p0 = perf_cnt;
`endif
            end else if (cfg_hit_p0) begin
                for (int k = 0; k < NumRegs; k++) begin
                    if (cfg_idx_p0 == 6'(k)) rdata_p0 = cfg_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumRegs; k++) cfg_q[k] <= '0;
        end else if (cfg_wr_p0) begin
            for (int k = 0; k < NumRegs; k++) begin
                if (cfg_idx_p0 == 6'(k)) cfg_q[k] <= apply_be(cfg_q[k], periph.data, periph.be);
            end
        end
    end

    for (genvar k = 0; k < NumRegs; k++) begin : g_cfg_out
        assign cfg_o[32*k +: 32] = cfg_q[k];
    end

    // Job FSM; a done_i set of the sticky bit overrides a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            start_o       <= 1'b0;
            irq_o         <= 1'b0;
            done_sticky_q <= 1'b0;
        end else begin
            start_o <= 1'b0;
            irq_o   <= 1'b0;
            if (stat_clr_p0) done_sticky_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trig_wr_p0) begin
                        state_q <= RUN;
                        start_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (done_i) begin
                        state_q       <= IDLE;
                        done_sticky_q <= 1'b1;
                        irq_o         <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stage p1: one-cycle response for every granted request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            periph.r_valid <= 1'b0;
            periph.r_data  <= '0;
            periph.r_id    <= '0;
        end else begin
            periph.r_valid <= periph.req;
            periph.r_data  <= rdata_p0;
            if (periph.req) periph.r_id <= periph.id;
        end
    end

endmodule

// File: tb/tb_snax_hwpe_regfile.sv
// Directed bench for snax_hwpe_regfile: vector table plus job-handshake sequences.
module tb_snax_hwpe_regfile;

    localparam int unsigned NumRegs = 8;

`ifdef SNAX_HWPE_REGFILE_PERF_EN
    localparam logic [31:0] PerfAfter17 = 32'd17;
    localparam logic [31:0] PerfFirst   = 32'd0;
    localparam logic [31:0] PerfSecond  = 32'd1;
`else
    localparam logic [31:0] PerfAfter17 = 32'd0;
    localparam logic [31:0] PerfFirst   = 32'd0;
    localparam logic [31:0] PerfSecond  = 32'd0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  done_i = 1'b0;
    logic                  start_o;
    logic                  irq_o;
    logic [NumRegs*32-1:0] cfg_o;

    int errors = 0;
    int checks = 0;

    hwpe_ctrl_intf_periph #(.ID_WIDTH(8)) periph_if ();

    snax_hwpe_regfile #(.NumRegs(NumRegs)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .periph  (periph_if.slave),
        .cfg_o   (cfg_o),
        .start_o (start_o),
        .done_i  (done_i),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] add;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called one time unit after a rising edge; returns one unit after the grant edge.
    task automatic xfer(input logic wen, input logic [31:0] add, input logic [3:0] be,
                        input logic [31:0] data, input logic [7:0] id,
                        input logic [31:0] exp, input string name);
        periph_if.req  = 1'b1;
        periph_if.wen  = wen;
        periph_if.add  = add;
        periph_if.be   = be;
        periph_if.data = data;
        periph_if.id   = id;
        #1;
        chk({name, "_gnt"}, 32'(periph_if.gnt), 32'd1);
        @(posedge clk);
        #1;
        chk({name, "_rvalid"}, 32'(periph_if.r_valid), 32'd1);
        chk({name, "_rid"}, 32'(periph_if.r_id), 32'(id));
        chk({name, "_rdata"}, periph_if.r_data, exp);
        periph_if.req = 1'b0;
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        @(posedge clk);
        #1;
        done_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        periph_if.req  = 1'b0;
        periph_if.wen  = 1'b1;
        periph_if.add  = '0;
        periph_if.be   = '0;
        periph_if.data = '0;
        periph_if.id   = '0;

        vecs[0]  = '{1'b0, 32'h0C, 4'b0101, 32'hA5A5_1234, 32'h0};
        vecs[1]  = '{1'b1, 32'h0C, 4'b0000, 32'h0,         32'h00A5_0034};
        vecs[2]  = '{1'b0, 32'h28, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[3]  = '{1'b1, 32'h28, 4'b0000, 32'h0,         32'hCAFE_F00D};
        vecs[4]  = '{1'b0, 32'h2C, 4'b1111, 32'h1234_5678, 32'h0};
        vecs[5]  = '{1'b1, 32'h2C, 4'b0000, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 32'hFC, 4'b0000, 32'h0,         32'h0};
        vecs[7]  = '{1'b0, 32'h13, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[8]  = '{1'b1, 32'h12, 4'b0000, 32'h0,         32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 32'h10, 4'b0000, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 32'h10, 4'b0000, 32'h0,         32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 32'h10, 4'b1000, 32'h1100_0000, 32'h0};
        vecs[12] = '{1'b1, 32'h10, 4'b0000, 32'h0,         32'h11AD_BEEF};
        vecs[13] = '{1'b0, 32'h10, 4'b1111, 32'h0,         32'h0};
        vecs[14] = '{1'b1, 32'h10, 4'b0000, 32'h0,         32'h0};
        vecs[15] = '{1'b0, 32'h08, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        vecs[16] = '{1'b1, 32'h08, 4'b0000, 32'h0,         32'h0};
        vecs[17] = '{1'b1, 32'h04, 4'b0000, 32'h0,         32'h0};
        vecs[18] = '{1'b0, 32'h00, 4'b0000, 32'h1,         32'h0};
        vecs[19] = '{1'b1, 32'h04, 4'b0000, 32'h0,         32'h0};

        // Reset state
        #12;
        chk("rst_rvalid", 32'(periph_if.r_valid), 32'd0);
        chk("rst_rdata", periph_if.r_data, 32'd0);
        chk("rst_rid", 32'(periph_if.r_id), 32'd0);
        chk("rst_start", 32'(start_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_cfg_any", 32'(|cfg_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back reads of all 32 word indices
        for (int i = 0; i < 32; i++) begin
            xfer(1'b1, 32'(i * 4), 4'b0000, 32'h0, 8'(i), 32'h0, $sformatf("rd_all%0d", i));
        end
        @(posedge clk);
        #1;
        chk("idle_rvalid", 32'(periph_if.r_valid), 32'd0);

        // Vector table
        for (int i = 0; i < 20; i++) begin
            xfer(vecs[i].wen, vecs[i].add, vecs[i].be, vecs[i].data, 8'(8'h40 + i),
                 vecs[i].exp, $sformatf("vec%0d", i));
        end
        chk("cfg_o_w0", cfg_o[31:0], 32'h00A5_0034);
        chk("cfg_o_w7", cfg_o[32*7 +: 32], 32'hCAFE_F00D);
        chk("no_start_be0", 32'(start_o), 32'd0);

        // Launch, frozen config, ignored re-trigger, completion
        xfer(1'b0, 32'h00, 4'b0001, 32'h0, 8'h80, 32'h0, "trig");
        chk("start_hi", 32'(start_o), 32'd1);
        xfer(1'b1, 32'h04, 4'b0000, 32'h0, 8'h81, 32'h1, "stat_busy");
        chk("start_lo", 32'(start_o), 32'd0);
        xfer(1'b0, 32'h10, 4'b1111, 32'hFFFF_FFFF, 8'h82, 32'h0, "cfg1_run_wr");
        xfer(1'b1, 32'h10, 4'b0000, 32'h0, 8'h83, 32'h0, "cfg1_run_rd");
        chk("cfg_o_w1_run", cfg_o[63:32], 32'h0);
        xfer(1'b0, 32'h00, 4'b1111, 32'h0, 8'h84, 32'h0, "trig_run");
        chk("start_run_trig", 32'(start_o), 32'd0);
        pulse_done();
        chk("irq_hi", 32'(irq_o), 32'd1);
        @(posedge clk);
        #1;
        chk("irq_lo", 32'(irq_o), 32'd0);
        xfer(1'b1, 32'h04, 4'b0000, 32'h0, 8'h85, 32'h2, "stat_done");

        // done_i in IDLE is ignored
        pulse_done();
        chk("irq_idle_done", 32'(irq_o), 32'd0);
        xfer(1'b1, 32'h04, 4'b0000, 32'h0, 8'h86, 32'h2, "stat_idle_done");

        // Trigger does not clear the sticky bit
        xfer(1'b0, 32'h00, 4'b0001, 32'h0, 8'h87, 32'h0, "trig2");
        chk("start2_hi", 32'(start_o), 32'd1);
        xfer(1'b1, 32'h04, 4'b0000, 32'h0, 8'h88, 32'h3, "stat_busy_sticky");

        // done_i with a same-cycle clear: set wins
        done_i = 1'b1;
        xfer(1'b0, 32'h04, 4'b0001, 32'h2, 8'h89, 32'h0, "clr_vs_done");
        done_i = 1'b0;
        chk("irq_clr_vs_done", 32'(irq_o), 32'd1);
        xfer(1'b1, 32'h04, 4'b0000, 32'h0, 8'h8A, 32'h2, "stat_set_wins");
        xfer(1'b0, 32'h04, 4'b0001, 32'h2, 8'h8B, 32'h0, "clr");
        xfer(1'b1, 32'h04, 4'b0000, 32'h0, 8'h8C, 32'h0, "stat_cleared");

        // done_i with a same-cycle trigger in RUN: trigger dropped
        xfer(1'b0, 32'h00, 4'b0001, 32'h0, 8'h8D, 32'h0, "trig3");
        done_i = 1'b1;
        xfer(1'b0, 32'h00, 4'b0001, 32'h0, 8'h8E, 32'h0, "trig_vs_done");
        done_i = 1'b0;
        chk("start_trig_vs_done", 32'(start_o), 32'd0);
        chk("irq_trig_vs_done", 32'(irq_o), 32'd1);
        xfer(1'b1, 32'h04, 4'b0000, 32'h0, 8'h8F, 32'h2, "stat_trig_vs_done");
        xfer(1'b0, 32'h04, 4'b0001, 32'h2, 8'h90, 32'h0, "clr2");

        // Performance counter: 17 RUN cycles, then restart
        xfer(1'b0, 32'h00, 4'b0001, 32'h0, 8'h91, 32'h0, "trig_perf");
        repeat (16) @(posedge clk);
        #1;
        pulse_done();
        chk("irq_perf", 32'(irq_o), 32'd1);
        xfer(1'b1, 32'h08, 4'b0000, 32'h0, 8'h92, PerfAfter17, "perf17");
        xfer(1'b1, 32'h04, 4'b0000, 32'h0, 8'h93, 32'h2, "stat_perf");
        xfer(1'b0, 32'h00, 4'b0001, 32'h0, 8'h94, 32'h0, "retrig_perf");
        xfer(1'b1, 32'h08, 4'b0000, 32'h0, 8'h95, PerfFirst, "perf_restart0");
        xfer(1'b1, 32'h08, 4'b0000, 32'h0, 8'h96, PerfSecond, "perf_restart1");
        pulse_done();
        xfer(1'b0, 32'h04, 4'b0001, 32'h2, 8'h97, 32'h0, "clr3");

        // Asynchronous reset in the middle of a job
        xfer(1'b0, 32'h0C, 4'b1111, 32'h1234_5678, 8'h98, 32'h0, "cfg0_pre_rst");
        xfer(1'b0, 32'h00, 4'b0001, 32'h0, 8'h99, 32'h0, "trig_pre_rst");
        chk("start_pre_rst", 32'(start_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_cfg_any", 32'(|cfg_o), 32'd0);
        chk("midrst_start", 32'(start_o), 32'd0);
        chk("midrst_rvalid", 32'(periph_if.r_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        pulse_done();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("post_rst_irq%0d", i), 32'(irq_o), 32'd0);
            @(posedge clk);
            #1;
        end
        xfer(1'b1, 32'h04, 4'b0000, 32'h0, 8'h9A, 32'h0, "stat_post_rst");
        xfer(1'b1, 32'h0C, 4'b0000, 32'h0, 8'h9B, 32'h0, "cfg0_post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
